// File: rtl/rot_pkg.sv
// Shared widths, types and the round-robin helper for the rotate arbiter slice.
package rot_pkg;

  localparam int W  = 32;
  localparam int SW = 5;

  typedef logic src_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Under contention the winner is whichever requester did not win last time.
  function automatic src_t rr_next(input src_t last_grant);
    return ~last_grant;
  endfunction

endpackage

// File: rtl/rot_core.sv
// Combinational rotate-right datapath; rot = 0 passes the word through unchanged.
module rot_core #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] amt,
  input  logic          rot,
  output logic [W-1:0]  result
);

  logic [SW:0] lshift_s;

  // amt = 0 makes the left shift a full-width shift, which yields zero.
  always_comb begin
    lshift_s = (SW + 1)'(W) - {1'b0, amt};
    if (rot) begin
      result = (data >> amt) | (data << lshift_s);
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/rot_arbiter.sv
// Round-robin share of one rotator between two requesters, with the result
// held in a single-entry valid/ready output register.
module rot_arbiter
  import rot_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_data,
  input  logic [SW-1:0] req0_amt,
  input  logic          req0_rot,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_data,
  input  logic [SW-1:0] req1_amt,
  input  logic          req1_rot,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_src
);

  state_t        state_r;
  state_t        state_next_s;
  src_t          last_grant_r;
  src_t          out_src_r;
  logic [W-1:0]  out_data_r;

  logic          space_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          any_grant_s;
  logic [W-1:0]  sel_data_s;
  logic [SW-1:0] sel_amt_s;
  logic          sel_rot_s;
  logic [W-1:0]  rot_result_s;

  assign out_valid  = (state_r == FULL);
  assign out_data   = out_data_r;
  assign out_src    = out_src_r;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Grant logic; rst_n gates it so no ready escapes while reset is held.
  always_comb begin
    space_s  = !out_valid || out_ready;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst_n && space_s) begin
      if (req0_valid && req1_valid) begin
        if (rr_next(last_grant_r) == 1'b0) begin
          grant0_s = 1'b1;
        end else begin
          grant1_s = 1'b1;
        end
      end else if (req0_valid) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign any_grant_s = grant0_s | grant1_s;

  // Steer the granted requester's fields into the single rotator.
  always_comb begin
    if (grant1_s) begin
      sel_data_s = req1_data;
      sel_amt_s  = req1_amt;
      sel_rot_s  = req1_rot;
    end else begin
      sel_data_s = req0_data;
      sel_amt_s  = req0_amt;
      sel_rot_s  = req0_rot;
    end
  end

  rot_core #(
    .W  (W),
    .SW (SW)
  ) u_rot_core (
    .data   (sel_data_s),
    .amt    (sel_amt_s),
    .rot    (sel_rot_s),
    .result (rot_result_s)
  );

  // Output register occupancy: a grant always fills it, a bare drain empties it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (any_grant_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (any_grant_s) begin
          state_next_s = FULL;
        end else if (out_ready) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Result, source and round-robin pointer load together on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r   <= {W{1'b0}};
      out_src_r    <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (any_grant_s) begin
      out_data_r   <= rot_result_s;
      out_src_r    <= grant1_s;
      last_grant_r <= grant1_s;
    end else begin
      out_data_r   <= out_data_r;
      out_src_r    <= out_src_r;
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: tb/tb_rot_arbiter.sv
// Self-checking bench for rot_arbiter: bench-side grant model plus a result scoreboard.
module tb_rot_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_rot;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, req1_rot;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic        out_valid, out_ready, out_src;
  logic [31:0] out_data;

  typedef struct packed {
    logic [31:0] data;
    logic        src;
  } exp_t;

  exp_t sb[$];
  logic model_ov;
  logic model_last;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rot_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_rot   (req0_rot),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_rot   (req1_rot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  // Bit-by-bit rotate-right reference: out[i] = d[(i + a) mod 32].
  function automatic logic [31:0] model_rot(input logic [31:0] d, input logic [4:0] a, input logic r);
    logic [31:0] o;
    if (!r) return d;
    for (int i = 0; i < 32; i++) o[i] = d[(i + int'(a)) % 32];
    return o;
  endfunction

  // Expected {grant1, grant0} from the bench's own view of occupancy and pointer.
  function automatic logic [1:0] model_grant();
    if (!rst_n) return 2'b00;
    if (model_ov && !out_ready) return 2'b00;
    if (req0_valid && req1_valid) return model_last ? 2'b01 : 2'b10;
    return {req1_valid, req0_valid};
  endfunction

  task automatic model_reset();
    model_ov   = 1'b0;
    model_last = 1'b1;
    sb.delete();
  endtask

  // Update the model for the current inputs, then advance one clock to the next negedge.
  task automatic drive_cycle();
    logic [1:0] g;
    g = model_grant();
    if (model_ov && out_ready && sb.size() > 0) void'(sb.pop_front());
    if (g[0]) begin
      sb.push_back('{data: model_rot(req0_data, req0_amt, req0_rot), src: 1'b0});
      model_last = 1'b0;
    end else if (g[1]) begin
      sb.push_back('{data: model_rot(req1_data, req1_amt, req1_rot), src: 1'b1});
      model_last = 1'b1;
    end
    if (g != 2'b00) model_ov = 1'b1;
    else if (out_ready) model_ov = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0; req0_amt = 5'd0; req0_rot = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0; req1_amt = 5'd0; req1_rot = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %08h want 00000000", out_data); end
    n_cmp++; if (out_src !== 1'b0) begin n_err++; $display("FAIL reset_out_src: got %0b want 0", out_src); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready_held: got %02b want 00", {req1_ready, req0_ready}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL reset_first_grant: got %02b want 01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_amt = 5'd1; req0_rot = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL single_ready: got %02b want 01", {req1_ready, req0_ready}); end
    drive_cycle();
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h8000_0000 || out_src !== 1'b0) begin n_err++; $display("FAIL single_result: got %08h/%0b want 80000000/0", out_data, out_src); end
    n_cmp++; if (sb.size() == 0 || out_data !== sb[0].data) begin n_err++; $display("FAIL single_sb: got %08h want %08h", out_data, sb[0].data); end
    drive_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_passthru();
    logic [4:0]  amts [3] = '{5'd7, 5'd0, 5'd31};
    logic        rots [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] want [3] = '{32'h1234_5678, 32'h1234_5678, 32'h2468_ACF0};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req1_valid = 1'b1; req1_data = 32'h1234_5678; req1_amt = amts[k]; req1_rot = rots[k];
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL pass_ready[%0d]: got %02b want 10", k, {req1_ready, req0_ready}); end
      drive_cycle();
      req1_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== want[k] || out_src !== 1'b1) begin
        n_err++; $display("FAIL pass_result[%0d]: got %0b/%08h/%0b want 1/%08h/1", k, out_valid, out_data, out_src, want[k]);
      end
      n_cmp++; if (sb.size() == 0 || out_data !== sb[0].data) begin n_err++; $display("FAIL pass_sb[%0d]: got %08h want %08h", k, out_data, sb[0].data); end
    end
    drive_cycle();
  endtask

  task automatic test_fairness();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1'b1; req0_data = $urandom; req0_amt = 5'($urandom_range(0, 31)); req0_rot = 1'b1;
      req1_valid = 1'b1; req1_data = $urandom; req1_amt = 5'($urandom_range(0, 31)); req1_rot = k[0];
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== model_grant()) begin n_err++; $display("FAIL fair_ready[%0d]: got %02b want %02b", k, {req1_ready, req0_ready}, model_grant()); end
      drive_cycle();
      n_cmp++; if (out_valid !== 1'b1 || out_src !== k[0]) begin n_err++; $display("FAIL fair_src[%0d]: got %0b/%0b want 1/%0b", k, out_valid, out_src, k[0]); end
      n_cmp++; if (sb.size() == 0 || out_data !== sb[0].data) begin n_err++; $display("FAIL fair_data[%0d]: got %08h want %08h", k, out_data, sb[0].data); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drive_cycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 32'hA5A5_0F0F; req0_amt = 5'd4; req0_rot = 1'b1;
    #1;
    drive_cycle();
    out_ready = 1'b0;
    req0_data = 32'hDEAD_BEEF; req0_amt = 5'd8;
    req1_valid = 1'b1; req1_data = 32'hCAFE_F00D; req1_amt = 5'd12; req1_rot = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d]: got %02b want 00", k, {req1_ready, req0_ready}); end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hFA5A_50F0 || out_src !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %0b/%08h/%0b want 1/fa5a50f0/0", k, out_valid, out_data, out_src);
      end
      drive_cycle();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL bp_release_ready: got %02b want 10", {req1_ready, req0_ready}); end
    drive_cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 1'b1 || sb.size() == 0 || out_data !== sb[0].data) begin
      n_err++; $display("FAIL bp_release_result: got %0b/%08h/%0b want 1/%08h/1", out_valid, out_data, out_src, sb[0].data);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drive_cycle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0F00_0000; req0_amt = 5'd24; req0_rot = 1'b1;
    #1;
    drive_cycle();
    req0_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0000_000F) begin n_err++; $display("FAIL mid_loaded: got %0b/%08h want 1/0000000f", out_valid, out_data); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_clear: got %0b want 0", out_valid); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL mid_ready_in_reset: got %02b want 00", {req1_ready, req0_ready}); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    req0_data = 32'h1111_2222; req0_amt = 5'd16;
    #1;
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL mid_first_grant: got %02b want 01", {req1_ready, req0_ready}); end
    drive_cycle();
    n_cmp++; if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 32'h2222_1111) begin
      n_err++; $display("FAIL mid_first_result: got %0b/%08h/%0b want 1/22221111/0", out_valid, out_data, out_src);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drive_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_passthru();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
